// File: rtl/sram_256x36_arb.sv
// rtl/sram_256x36_arb.sv - three-requester round-robin arbiter onto a dual-port 256x36 SRAM
//
// Optional feature macro: SRAM_ARB_INIT_EN (zero-fill of the whole SRAM after every reset).
//
// Ports:
//   RW0_clk                 single clock, all state and both SRAM ports on its rising edge
//   rst_n                   asynchronous active-low reset
//   req_valid/req_write     per-requester request valid and write flag (bit i = requester i)
//   req_addr/req_wdata      per-requester address and write data, requester i in slice i
//   req_ready               per-requester grant, combinational; transfer = valid & ready
//   rsp_valid/rsp_rdata     read response one cycle after a granted read, slice i
//   RW0_*/RW1_*             two SRAM ports (en, wmode, addr, wdata out; rdata in)
//   init_busy               high while the zero-fill sequence runs
module sram_256x36_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 36,
    parameter int DEPTH  = 256
) (
    input  logic                  RW0_clk,
    input  logic                  rst_n,
    input  logic [2:0]            req_valid,
    output logic [2:0]            req_ready,
    input  logic [2:0]            req_write,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_wdata,
    output logic [2:0]            rsp_valid,
    output logic [3*DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]     RW0_addr,
    output logic                  RW0_en,
    output logic                  RW0_wmode,
    output logic [DATA_W-1:0]     RW0_wdata,
    input  logic [DATA_W-1:0]     RW0_rdata,
    output logic [ADDR_W-1:0]     RW1_addr,
    output logic                  RW1_en,
    output logic                  RW1_wmode,
    output logic [DATA_W-1:0]     RW1_wdata,
    input  logic [DATA_W-1:0]     RW1_rdata,
    output logic                  init_busy
);

    logic [ADDR_W-1:0] a      [3];
    logic [DATA_W-1:0] d      [3];
    logic [DATA_W-1:0] hold_q [3];
    logic [DATA_W-1:0] rsp_c  [3];
    logic [1:0]        rr;
    logic [1:0]        cand;
    logic              run;
    logic              g0_vld;
    logic              g1_vld;
    logic [1:0]        g0_idx;
    logic [1:0]        g1_idx;
    logic [2:0]        port_id;

    function automatic logic [1:0] next3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

`ifdef SRAM_ARB_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(DEPTH / 2);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    // Each INIT cycle clears one word in each half, so DEPTH/2 cycles cover the array.
    always_ff @(posedge RW0_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == HALF - 1'b1) begin
                state <= ST_RUN;
            end
        end
    end

    assign run       = (state == ST_RUN);
    assign init_busy = (state == ST_INIT);
`else
    assign run       = 1'b1;
    assign init_busy = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            a[i] = req_addr[i*ADDR_W +: ADDR_W];
            d[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Walk requesters in rr order: first valid takes RW0, the next valid one that
    // does not collide with it (same address with a write on either side) takes RW1.
    always_comb begin
        g0_vld = 1'b0;
        g0_idx = 2'd0;
        g1_vld = 1'b0;
        g1_idx = 2'd0;
        cand   = rr;
        for (int k = 0; k < 3; k++) begin
            if (req_valid[cand] && run && rst_n) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = cand;
                end else if (!g1_vld &&
                             !((a[g0_idx] == a[cand]) && (req_write[g0_idx] || req_write[cand]))) begin
                    g1_vld = 1'b1;
                    g1_idx = cand;
                end
            end
            cand = next3(cand);
        end
    end

    always_comb begin
        req_ready = '0;
        if (g0_vld) req_ready[g0_idx] = 1'b1;
        if (g1_vld) req_ready[g1_idx] = 1'b1;
    end

    // SRAM ports are forced idle while reset is held, even though INIT is the reset state.
    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = a[g0_idx];
        RW0_wdata = d[g0_idx];
        RW1_en    = 1'b0;
        RW1_wmode = 1'b0;
        RW1_addr  = a[g1_idx];
        RW1_wdata = d[g1_idx];
        if (rst_n) begin
`ifdef SRAM_ARB_INIT_EN
            if (state == ST_INIT) begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = cnt;
                RW0_wdata = '0;
                RW1_en    = 1'b1;
                RW1_wmode = 1'b1;
                RW1_addr  = cnt + HALF;
                RW1_wdata = '0;
            end else
`endif
            begin
                RW0_en    = g0_vld;
                RW0_wmode = req_write[g0_idx];
                RW1_en    = g1_vld;
                RW1_wmode = req_write[g1_idx];
            end
        end
    end

    // SRAM read data arrives the cycle after the grant; it is steered live while
    // rsp_valid is high and captured so the slice holds afterwards.
    always_comb begin
        rsp_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            rsp_c[i] = rsp_valid[i] ? (port_id[i] ? RW1_rdata : RW0_rdata) : hold_q[i];
            rsp_rdata[i*DATA_W +: DATA_W] = rsp_c[i];
        end
    end

    always_ff @(posedge RW0_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr        <= 2'd0;
            rsp_valid <= '0;
            port_id   <= '0;
            for (int i = 0; i < 3; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            if (g0_vld) begin
                rr <= g1_vld ? next3(g1_idx) : next3(g0_idx);
            end
            for (int i = 0; i < 3; i++) begin
                if (rsp_valid[i]) begin
                    hold_q[i] <= rsp_c[i];
                end
                rsp_valid[i] <= 1'b0;
                if (g0_vld && (g0_idx == 2'(i)) && !req_write[i]) begin
                    rsp_valid[i] <= 1'b1;
                    port_id[i]   <= 1'b0;
                end
                if (g1_vld && (g1_idx == 2'(i)) && !req_write[i]) begin
                    rsp_valid[i] <= 1'b1;
                    port_id[i]   <= 1'b1;
                end
            end
        end
    end

endmodule
